// File: rtl/controller_pkg.sv
// Shared definitions for the serial game-controller reader: FSM states,
// frame width and the button bit positions in the decoded word.
package controller_pkg;

  localparam int CTRL_BITS = 8;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/ctrl_tick_counter.sv
// Modulo-N down-counter: load or wrap returns it to N-1, tc flags the zero count.
// Reset value N-1 corresponds to "no cycles elapsed yet".
module ctrl_tick_counter #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] TOP = W'(N - 1);

  logic [W-1:0] cnt_r;

  // Count state: reload on load or after reaching zero, otherwise step down when enabled
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r <= TOP;
    end else if (load) begin
      cnt_r <= TOP;
    end else if (en) begin
      if (cnt_r == {W{1'b0}}) begin
        cnt_r <= TOP;
      end else begin
        cnt_r <= cnt_r - W'(1);
      end
    end
  end

  assign tc = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/controller_reader.sv
// Console-side reader for the 8-bit serial pad: latches the pad, samples MSB-first
// with CLK_DIV spacing, and publishes the active-high button word with Valid/Changed.
module controller_reader
  import controller_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_CYCLES = 833333,
  parameter int NUM_BITS    = CTRL_BITS
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                Auto_Poll,
  input  logic                Ser_Data,
  output logic                Load,
  output logic                Shift_Enable,
  output logic [NUM_BITS-1:0] Buttons,
  output logic                Valid,
  output logic                Changed,
  output logic                Busy
);

  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

  ctrl_state_e         state_r, state_s;
  logic [NUM_BITS-1:0] shift_r, shift_s;
  logic [BW-1:0]       bit_cnt_r;
  logic [NUM_BITS-1:0] buttons_r;
  logic                load_r, shift_en_r, valid_r, changed_r, busy_r;
  logic                launch_s, wait_load_s, wait_tc_s;
  logic                poll_load_s, poll_en_s, poll_tc_s;

  // WAIT lasts CLK_DIV-1 cycles; counter is armed on every entry into WAIT
  ctrl_tick_counter #(.N(CLK_DIV - 1)) u_bit_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (wait_load_s),
    .en      (state_r == ST_WAIT),
    .tc      (wait_tc_s)
  );

  assign poll_load_s = launch_s || !Auto_Poll;
  assign poll_en_s   = (state_r == ST_IDLE) && Auto_Poll;

  ctrl_tick_counter #(.N(POLL_CYCLES)) u_poll_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (poll_load_s),
    .en      (poll_en_s),
    .tc      (poll_tc_s)
  );

  // Next-state, launch decision and shift-register update
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    launch_s    = 1'b0;
    wait_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start || (Auto_Poll && poll_tc_s)) begin
          launch_s = 1'b1;
          state_s  = ST_LATCH;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_LATCH: begin
        state_s     = ST_WAIT;
        wait_load_s = 1'b1;
      end
      ST_WAIT: begin
        if (wait_tc_s) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        shift_s = {shift_r[NUM_BITS-2:0], Ser_Data};
        if (bit_cnt_r == LAST_BIT) begin
          state_s = ST_DONE;
        end else begin
          state_s     = ST_WAIT;
          wait_load_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered pulse outputs, all derived from the next state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= {NUM_BITS{1'b1}};
      bit_cnt_r  <= {BW{1'b0}};
      buttons_r  <= {NUM_BITS{1'b0}};
      load_r     <= 1'b0;
      shift_en_r <= 1'b0;
      valid_r    <= 1'b0;
      changed_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      if (launch_s) begin
        bit_cnt_r <= {BW{1'b0}};
      end else if (state_r == ST_SAMPLE) begin
        bit_cnt_r <= bit_cnt_r + BW'(1);
      end
      load_r     <= (state_s == ST_LATCH);
      shift_en_r <= (state_s == ST_SAMPLE) && (bit_cnt_r != LAST_BIT);
      valid_r    <= (state_s == ST_DONE);
      busy_r     <= (state_s != ST_IDLE);
      // Pad data is active-low, so the published word is the inverted capture
      if (state_s == ST_DONE) begin
        buttons_r <= ~shift_s;
        changed_r <= (~shift_s != buttons_r);
      end else begin
        changed_r <= 1'b0;
      end
    end
  end

  assign Load         = load_r;
  assign Shift_Enable = shift_en_r;
  assign Buttons      = buttons_r;
  assign Valid        = valid_r;
  assign Changed      = changed_r;
  assign Busy         = busy_r;

endmodule
